seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multiplexed 7-segment driver for the digital-clock board family.
- Time-multiplexes NUM_DIGITS hex digits onto a shared active-low segment bus with active-low digit selects.
- Adds features the current driver lacks: full 0-F decode, inter-digit dead time (anti-ghosting), 16-level PWM brightness, per-digit blink and blank, leading-zero suppression, tear-free frame snapshot, and a frame_tick output.
- Sits between the clock/alarm datapath and the board pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; range 1..8.
- SCAN_DIV, 65536, clk cycles per digit slot; multiple of 16, at least 32.
- BLANK_CYCLES, 256, dead time at the start of each slot during which all selects are off; multiple of 16, less than SCAN_DIV.
- BLINK_DIV, 25000000, clk cycles per blink half-period.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  4*NUM_DIGITS  hex value per digit; digit i is bits [4i+3:4i]; digit 0 is least significant and rightmost.
- dp_in  in  NUM_DIGITS  decimal point request, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = force digit dark, including its dp.
- blink_in  in  NUM_DIGITS  1 = digit blinks.
- lz_suppress  in  1  1 = leading-zero suppression enabled.
- brightness  in  4  duty level; 0 = 1/16, 15 = 16/16.
- an  out  NUM_DIGITS  digit selects, active-low.
- sseg  out  8  segments, active-low; [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - an all ones, sseg 8'hFF, frame_tick 0.
  - slot_cnt, dig_idx and blink_cnt cleared; blink_phase 0.
  - Snapshot registers cleared.
  - Reset mid-frame aborts the scan immediately; on release, scanning restarts at digit 0, slot_cnt 0.
- Slot counter:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At each wrap, dig_idx increments, wrapping from NUM_DIGITS-1 to 0.
- Frame start (wrap into dig_idx 0):
  - frame_tick = 1 for exactly one cycle.
  - digits_in, dp_in, blank_in, blink_in, lz_suppress and brightness are captured into the snapshot.
  - All display decisions use only the snapshot, so input changes mid-frame never tear the display.
  - After reset, the first snapshot is taken at cycle 0 of the first frame, and frame_tick pulses then.
- Blink: blink_cnt counts 0..BLINK_DIV-1; blink_phase toggles on each wrap.
- Digit lit (lit = 1) when all of the following hold:
  - slot_cnt >= BLANK_CYCLES;
  - slot_cnt[3:0] <= snapshot brightness;
  - digit is not blanked: blank bit clear, and not (blink bit set and blink_phase = 1).
- Leading-zero suppression:
  - A digit i > 0 is suppressed when lz_suppress = 1, its value is 0, and every digit j > i is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows no segments, but its dp still follows dp_in.
- Segment value:
  - sseg[7:1] = decode(value), or all ones if suppressed.
  - sseg[0] = ~dp.
  - Decode, a..g active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Outputs are registered; latency is 1 cycle from counter state to pins.
- When lit = 0: an = all ones and sseg = 8'hFF.
- When lit = 1: exactly one an bit is low (an[dig_idx]).
- The an and sseg registers update in the same cycle, so no glitch pattern ever reaches the pins.

Decomposition:
- Package seg_disp_pkg holds:
  - segment bit-position constants;
  - SEG_OFF = 8'hFF;
  - the 16-entry decode constant table.
- One combinational sub-module, seg_hex_decoder: 4-bit value in, 7-bit active-low pattern out.
- The scan, PWM, blink, snapshot and suppression logic stays in the top module.

Test Plan:
- Bench parameters: NUM_DIGITS=4, SCAN_DIV=64, BLANK_CYCLES=16, BLINK_DIV=512.
- Reset held, then released -> an = 4'hF and sseg = 8'hFF until slot_cnt = 16. frame_tick pulses once per 256 cycles; the first pulse is at cycle 0 after release.
- digits_in = 16'h3A0F, brightness = 15, no blank/blink -> within each slot, an low for cycles 17..64.
  - an = 1110 shows F (0111000 with dp bit 1).
  - an = 1101 shows 0; an = 1011 shows A; an = 0111 shows 3.
- brightness = 3 -> in each 16-cycle group past the dead time, the digit is lit exactly 4 cycles; no an bit is low during slot cycles 0..15.
- lz_suppress = 1, digits_in = 16'h0050, dp_in = 4'b1000 -> digit 3: sseg = 8'hFE (dp only); digit 2: 8'hFF; digit 1 shows 5; digit 0 shows 0.
- blink_in = 4'b0001 -> digit 0 dark for 512 cycles and normal for 512 cycles, alternating; other digits are unaffected.
- digits_in changed mid-frame -> pins keep old values until the next frame_tick and show the new values from that frame onward.
- Reset asserted mid-slot -> an and sseg go to all ones asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low: a 0 bit lights that segment.
package seg_disp_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry v holds the a..g pattern for hex value v (entry 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-7-segment decoder.
// Output bits [6:0] map to segments a..g, active-low.
module seg_hex_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[value];
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed hex display scanner with dead time, PWM dimming, blink,
// blank, leading-zero suppression and per-frame input snapshot.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LIT   = SLOT_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [DIG_W-1:0]   dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               frame_start;

    logic [NUM_DIGITS-1:0][3:0] snap_digits;
    logic [NUM_DIGITS-1:0]      snap_dp;
    logic [NUM_DIGITS-1:0]      snap_blank;
    logic [NUM_DIGITS-1:0]      snap_blink;
    logic                       snap_lz;
    logic [3:0]                 snap_bri;

    logic [NUM_DIGITS-1:0] supp_vec;
    logic [3:0]            cur_val;
    logic [6:0]            dec_seg;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [7:0]            sseg_nxt;

    assign frame_start = (slot_cnt == '0) && (dig_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            dig_idx     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
            snap_bri    <= '0;
        end else if (frame_start) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
            snap_blank  <= blank_in;
            snap_blink  <= blink_in;
            snap_lz     <= lz_suppress;
            snap_bri    <= brightness;
        end
    end

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (snap_digits[i] == 4'h0);
            supp_vec[i] = snap_lz && zero_run && (i > 0);
        end
    end

    assign cur_val = snap_digits[dig_idx];

    seg_hex_decoder u_dec (
        .value (cur_val),
        .seg   (dec_seg)
    );

    always_comb begin
        lit = (slot_cnt >= SLOT_LIT)
           && (slot_cnt[3:0] <= snap_bri)
           && !snap_blank[dig_idx]
           && !(snap_blink[dig_idx] && blink_phase);
        an_nxt   = '1;
        sseg_nxt = SEG_OFF;
        if (lit) begin
            an_nxt[dig_idx] = 1'b0;
            sseg_nxt[SEG_A_BIT:SEG_G_BIT] = supp_vec[dig_idx] ? 7'h7F : dec_seg;
            sseg_nxt[SEG_DP_BIT] = ~snap_dp[dig_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            sseg       <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            sseg       <= sseg_nxt;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised bench for seg_scan_display against a cycle-indexed
// reference model derived from the display rules.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int SD = 64;
    localparam int BC = 16;
    localparam int BD = 512;
    localparam int FR = SD * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  brightness = '0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int e = 0;

    logic [3:0] m_dig [4];
    logic [3:0] m_dp, m_blank, m_blink, m_bri;
    logic       m_lz;

    logic [3:0] x_an = 4'hF;
    logic [7:0] x_seg = 8'hFF;
    logic       x_ft = 1'b0;

    seg_scan_display #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_DIV    (BD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .an          (an),
        .sseg        (sseg),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     tag, e, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < ND; i++) m_dig[i] = '0;
        m_dp = '0; m_blank = '0; m_blink = '0; m_bri = '0; m_lz = 1'b0;
        e = 0;
    endtask

    // Expected pins after edge number e, from the frame snapshot.
    task automatic model();
        int  s, slot, d;
        bit  ph, lit, sup;
        s    = e % FR;
        slot = s % SD;
        d    = s / SD;
        ph   = ((e / BD) % 2) == 1;
        lit  = (slot >= BC) && ((slot % 16) <= int'(m_bri))
            && !m_blank[d] && !(m_blink[d] && ph);
        sup  = (d > 0) && m_lz;
        for (int j = d; j < ND; j++) if (m_dig[j] != 0) sup = 0;
        x_an  = 4'hF;
        x_seg = 8'hFF;
        if (lit) begin
            x_an[d] = 1'b0;
            x_seg   = {sup ? 7'h7F : hex7(m_dig[d]), ~m_dp[d]};
        end
        x_ft = (s == 0);
        if (s == 0) begin
            for (int i = 0; i < ND; i++) m_dig[i] = digits_in[4*i +: 4];
            m_dp = dp_in; m_blank = blank_in; m_blink = blink_in;
            m_lz = lz_suppress; m_bri = brightness;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        e++;
        @(negedge clk);
        check("an", 32'(an), 32'(x_an));
        check("sseg", 32'(sseg), 32'(x_seg));
        check("frame_tick", 32'(frame_tick), 32'(x_ft));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_in(input logic [15:0] dg, input logic [3:0] dp,
                          input logic [3:0] bl, input logic [3:0] bk,
                          input logic lz, input logic [3:0] br);
        digits_in = dg; dp_in = dp; blank_in = bl; blink_in = bk;
        lz_suppress = lz; brightness = br;
    endtask

    initial begin
        logic [15:0] masks [4];
        masks[0] = 16'hFFFF; masks[1] = 16'h00FF;
        masks[2] = 16'h000F; masks[3] = 16'h0F0F;

        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_sseg", 32'(sseg), 32'hFF);
        check("rst_tick", 32'(frame_tick), 32'h0);
        clear_model();
        set_in(16'h3A0F, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        rst_n = 1'b1;
        run(2 * FR);

        brightness = 4'd3;
        run(2 * FR);

        set_in(16'h0050, 4'b1000, 4'h0, 4'h0, 1'b1, 4'd15);
        run(2 * FR);

        set_in(16'h1234, 4'b0101, 4'h0, 4'b0001, 1'b0, 4'd15);
        run(5 * FR);

        blink_in = 4'h0;
        run(100);
        digits_in = 16'hBEEF;
        run(FR + 60);
        digits_in = 16'h00C7;
        dp_in = 4'b0010;
        run(FR);

        for (int k = 0; k < 16; k++) begin
            set_in(16'($urandom) & masks[$urandom_range(0, 3)],
                   4'($urandom), 4'($urandom & $urandom & $urandom),
                   4'($urandom & $urandom), 1'($urandom),
                   4'($urandom));
            run($urandom_range(40, 400));
        end

        set_in(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        run(FR);
        for (int k = 0; k < 2 * FR && x_an == 4'hF; k++) step();
        check("lit_before_reset", 32'(x_an != 4'hF), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_sseg", 32'(sseg), 32'hFF);
        check("async_rst_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk);
        check("hold_rst_an", 32'(an), 32'hF);
        clear_model();
        set_in(16'h9D02, 4'b0011, 4'h0, 4'h0, 1'b1, 4'd7);
        rst_n = 1'b1;
        run(2 * FR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
